writeback_stage: RTL

MEM/WB pipeline register and writeback unit of the RISC-V core. Registers the memory-stage result, aligns and extends load data, and selects the write value. Merges results from the long-latency multiply/divide unit through a one-entry pending buffer. Drives the register file write port directly; the register file commits on the following falling edge.

---
 rtl/writeback_stage.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and register-file write port. Pipe results and a
// one-entry mul/div pending buffer share the port; aging prevents starvation.
module writeback_stage #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemValid,
    input  logic        MemRegWrite,
    input  logic [4:0]  MemRd,
    input  logic [1:0]  MemResultSel,
    input  logic [31:0] MemAluResult,
    input  logic [31:0] MemPcPlus4,
    input  logic [2:0]  MemLoadType,
    input  logic [31:0] MemReadData,
    input  logic        StallW,
    input  logic        FlushW,
    input  logic        DivValid,
    input  logic [4:0]  DivRd,
    input  logic [31:0] DivResult,
    output logic        DivReady,
    output logic        RegWriteEN3,
    output logic [4:0]  Address3,
    output logic [31:0] RegDataW3,
    output logic        PendValid,
    output logic [4:0]  PendRd,
    output logic        WbStallReq
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic        valid_q, valid_d;
    logic        regwrite_q, regwrite_d;
    logic [4:0]  rd_q, rd_d;
    logic [1:0]  sel_q, sel_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] pc4_q, pc4_d;
    logic [2:0]  loadtype_q, loadtype_d;
    logic [31:0] rdata_q, rdata_d;
    logic        pend_valid_q, pend_valid_d;
    logic [4:0]  pend_rd_q, pend_rd_d;
    logic [31:0] pend_data_q, pend_data_d;
    logic [3:0]  age_q, age_d;

    logic        load_stage, pw, wb_stall, buf_owns, pipe_owns;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data, pipe_data;

    always_comb begin
        wb_stall   = pend_valid_q && (age_q == LIMIT);
        load_stage = !StallW && !wb_stall;

        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        rd_d       = rd_q;
        sel_d      = sel_q;
        alu_d      = alu_q;
        pc4_d      = pc4_q;
        loadtype_d = loadtype_q;
        rdata_d    = rdata_q;
        if (load_stage) begin
            valid_d    = MemValid && !FlushW;
            regwrite_d = MemRegWrite;
            rd_d       = MemRd;
            sel_d      = MemResultSel;
            alu_d      = MemAluResult;
            pc4_d      = MemPcPlus4;
            loadtype_d = MemLoadType;
            rdata_d    = MemReadData;
        end else if (FlushW) begin
            valid_d = 1'b0;
        end

        case (alu_q[1:0])
            2'd0:    byte_sel = rdata_q[7:0];
            2'd1:    byte_sel = rdata_q[15:8];
            2'd2:    byte_sel = rdata_q[23:16];
            default: byte_sel = rdata_q[31:24];
        endcase
        half_sel = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (loadtype_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'b0, byte_sel};
            3'b101:  load_data = {16'b0, half_sel};
            default: load_data = rdata_q;
        endcase
        case (sel_q)
            2'b01:   pipe_data = load_data;
            2'b10:   pipe_data = pc4_q;
            default: pipe_data = alu_q;
        endcase

        pw        = valid_q && regwrite_q && (rd_q != 5'd0);
        buf_owns  = wb_stall || (!pw && pend_valid_q);
        pipe_owns = pw && !wb_stall;

        RegWriteEN3 = 1'b0;
        Address3    = 5'd0;
        RegDataW3   = 32'd0;
        if (buf_owns) begin
            RegWriteEN3 = 1'b1;
            Address3    = pend_rd_q;
            RegDataW3   = pend_data_q;
        end else if (pipe_owns) begin
            RegWriteEN3 = 1'b1;
            Address3    = rd_q;
            RegDataW3   = pipe_data;
        end

        // Younger pipe write to the same rd makes the buffered value dead.
        pend_valid_d = pend_valid_q;
        pend_rd_d    = pend_rd_q;
        pend_data_d  = pend_data_q;
        if (buf_owns || (pend_valid_q && pipe_owns && (rd_q == pend_rd_q))) begin
            pend_valid_d = 1'b0;
        end
        if (DivValid && !pend_valid_q && (DivRd != 5'd0)) begin
            pend_valid_d = 1'b1;
            pend_rd_d    = DivRd;
            pend_data_d  = DivResult;
        end

        age_d = age_q;
        if (!pend_valid_q || !pend_valid_d) begin
            age_d = 4'd0;
        end else if (pipe_owns && (age_q < LIMIT)) begin
            age_d = age_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            regwrite_q   <= 1'b0;
            rd_q         <= 5'd0;
            sel_q        <= 2'd0;
            alu_q        <= 32'd0;
            pc4_q        <= 32'd0;
            loadtype_q   <= 3'd0;
            rdata_q      <= 32'd0;
            pend_valid_q <= 1'b0;
            pend_rd_q    <= 5'd0;
            pend_data_q  <= 32'd0;
            age_q        <= 4'd0;
        end else begin
            valid_q      <= valid_d;
            regwrite_q   <= regwrite_d;
            rd_q         <= rd_d;
            sel_q        <= sel_d;
            alu_q        <= alu_d;
            pc4_q        <= pc4_d;
            loadtype_q   <= loadtype_d;
            rdata_q      <= rdata_d;
            pend_valid_q <= pend_valid_d;
            pend_rd_q    <= pend_rd_d;
            pend_data_q  <= pend_data_d;
            age_q        <= age_d;
        end
    end

    assign DivReady   = !pend_valid_q;
    assign PendValid  = pend_valid_q;
    assign PendRd     = pend_valid_q ? pend_rd_q : 5'd0;
    assign WbStallReq = wb_stall;

endmodule
